// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first set bit of req searching upward from ptr+1, wrapping.
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  always_comb begin
    idx     = '0;
    any_req = |req;
    // Walk offsets high to low so the smallest offset past ptr is assigned last.
    for (int unsigned k = N; k >= 1; k--) begin
      if (req[IW'((32'(ptr) + k) % N)]) begin
        idx = IW'((32'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-granting round-robin arbiter muxing NUM_REQ beat streams into one FIFO write port.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  localparam int unsigned IDW  = idx_width(NUM_REQ),
  localparam int unsigned CNTW = $clog2(MAX_BURST) + 1
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  arb_state_t            state;
  logic [IDW-1:0]        owner;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        sel_idx;
  logic                  any_req;
  logic                  granted;
  logic                  last_beat;
  logic [CNTW-1:0]       beat_cnt;
  logic [DATA_WIDTH-1:0] lane_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_select #(.N(NUM_REQ)) u_rr_select (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .idx     (sel_idx),
    .any_req (any_req)
  );

  // Reset forces the handshake outputs low in the same cycle, so no beat lands on a reset edge.
  assign granted   = (state == GRANT) && !wrst;
  assign busy      = granted;
  assign w_en      = granted && req_valid[owner] && !full;
  assign data_in   = lane_data[owner];
  assign grant_id  = owner;
  assign last_beat = req_last[owner] || (beat_cnt == CNTW'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    if (granted) begin
      req_ready[owner] = !full;
    end
  end

  // Owner is cleared on release so grant_id reads 0 throughout IDLE.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= IDW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= sel_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (w_en) begin
            beat_cnt <= beat_cnt + CNTW'(1);
            if (last_beat) begin
              state  <= IDLE;
              rr_ptr <= owner;
              owner  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: per-requester packet sources, beat scoreboard, grant log.
module tb_fifo_write_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 16;
  localparam int unsigned IW = 2;

  logic              wclk = 1'b0;
  logic              wrst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR-1:0]     req_ready;
  logic              full = 1'b0;
  logic              w_en;
  logic [DW-1:0]     data_in;
  logic [IW-1:0]     grant_id;
  logic              busy;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .full      (full),
    .w_en      (w_en),
    .data_in   (data_in),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; } exp_t;
  typedef struct packed { logic [IW-1:0] id; logic [7:0] cnt; } grant_t;

  beat_t  src_q [NR][$];
  exp_t   exp_q [$];
  grant_t grant_log [$];
  grant_t grant_exp [$];
  grant_t cur_grant = '0;

  int   checks = 0;
  int   errors = 0;
  logic rst_ctl = 1'b1;
  logic full_ctl = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int id, input int pkt, input int b);
    return {8'(id), 8'(pkt), 16'(b)};
  endfunction

  task automatic push_pkt(input int id, input int pkt, input int n, input bit has_last);
    for (int b = 0; b < n; b++) begin
      src_q[id].push_back({beat_data(id, pkt, b), 1'(has_last && (b == n - 1))});
    end
  endtask

  task automatic expect_beats(input int id, input int pkt, input int first, input int n);
    for (int b = first; b < first + n; b++) begin
      exp_q.push_back({IW'(id), beat_data(id, pkt, b)});
    end
  endtask

  task automatic expect_grant(input int id, input int cnt);
    grant_exp.push_back({IW'(id), 8'(cnt)});
  endtask

  // Packet sources: inputs change only on negedge; a handshake is latched just before the posedge.
  initial begin : source
    logic [NR-1:0] hs;
    hs = '0;
    forever begin
      @(negedge wclk);
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      wrst = rst_ctl;
      full = full_ctl;
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]            = 1'b1;
          req_data[i*DW +: DW]    = src_q[i][0].data;
          req_last[i]             = src_q[i][0].last;
        end else begin
          req_valid[i]            = 1'b0;
          req_data[i*DW +: DW]    = '0;
          req_last[i]             = 1'b0;
        end
      end
      #1;
      hs = req_valid & req_ready;
    end
  end

  // Monitor: pops the scoreboard on every write and logs grant lengths.
  initial begin : monitor
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge wclk);
      #2;
      if (busy && !prev_busy) begin
        cur_grant.id  = grant_id;
        cur_grant.cnt = '0;
      end
      if (!busy && prev_busy) grant_log.push_back(cur_grant);
      if (busy && prev_busy && grant_id != cur_grant.id) begin
        check("owner_change_without_idle", 64'(grant_id), 64'(cur_grant.id));
      end
      if (w_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(data_in), 64'hDEAD_BEEF_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("write_data", 64'(data_in), 64'(e.data));
          check("write_owner", 64'(grant_id), 64'(e.id));
          check("ready_onehot", 64'(req_ready), 64'(4'b0001 << e.id));
        end
        cur_grant.cnt = cur_grant.cnt + 8'd1;
      end
      prev_busy = busy;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic sample();
    @(negedge wclk);
    #3;
  endtask

  task automatic do_reset();
    rst_ctl = 1'b1;
    sample();
    sample();
    check("rst_w_en", 64'(w_en), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    grant_log.delete();
    grant_exp.delete();
    rst_ctl = 1'b0;
    sample();
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      sample();
      n++;
    end
    check({name, "_pending_beats"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle_at_end"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_beat(input logic [DW-1:0] d, input string name);
    int n = 0;
    sample();
    while (!(w_en && data_in == d) && n < 100) begin
      sample();
      n++;
    end
    check({name, "_beat_seen"}, 64'(w_en && data_in == d), 64'd1);
  endtask

  task automatic check_grants(input string name);
    check({name, "_grant_count"}, 64'(grant_log.size()), 64'(grant_exp.size()));
    for (int i = 0; i < grant_exp.size() && i < grant_log.size(); i++) begin
      check({name, "_grant_id"}, 64'(grant_log[i].id), 64'(grant_exp[i].id));
      check({name, "_grant_beats"}, 64'(grant_log[i].cnt), 64'(grant_exp[i].cnt));
    end
  endtask

  initial begin : main
    do_reset();

    // Requesters 1 and 2 valid after reset: 1 wins, then 2 after an idle cycle.
    push_pkt(1, 0, 3, 1'b1);
    push_pkt(2, 0, 2, 1'b1);
    expect_beats(1, 0, 0, 3);
    expect_beats(2, 0, 0, 2);
    expect_grant(1, 3);
    expect_grant(2, 2);
    sample();
    check("b_valid_seen", 64'(req_valid), 64'(4'b0110));
    check("b_arbitration_cycle_idle", 64'(busy), 64'd0);
    sample();
    check("b_grant_id", 64'(grant_id), 64'd1);
    check("b_busy", 64'(busy), 64'd1);
    wait_drain("b", 50);
    check_grants("b");

    // All four requesters with two 2-beat packets each.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int id = 0; id < 4; id++) begin
        push_pkt(id, p, 2, 1'b1);
        expect_beats(id, p, 0, 2);
        expect_grant(id, 2);
      end
    end
    wait_drain("c", 100);
    check_grants("c");

    // Requester 3 streams 40 beats without last: grants of 16, 16, then 8 held open.
    do_reset();
    push_pkt(3, 0, 40, 1'b0);
    expect_beats(3, 0, 0, 40);
    expect_grant(3, 16);
    expect_grant(3, 16);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        sample();
        n++;
      end
    end
    repeat (3) sample();
    check("d_pending_beats", 64'(exp_q.size()), 64'd0);
    check("d_still_busy", 64'(busy), 64'd1);
    check("d_still_owner", 64'(grant_id), 64'd3);
    check("d_stalled_no_write", 64'(w_en), 64'd0);
    check("d_final_grant_beats", 64'(cur_grant.cnt), 64'd8);
    check_grants("d");

    // full held 5 cycles mid-burst; the 16-beat release proves the counter held.
    do_reset();
    push_pkt(1, 0, 18, 1'b1);
    expect_beats(1, 0, 0, 18);
    expect_grant(1, 16);
    expect_grant(1, 2);
    wait_beat(beat_data(1, 0, 1), "f");
    full_ctl = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      check("f_full_w_en", 64'(w_en), 64'd0);
      check("f_full_req_ready", 64'(req_ready), 64'd0);
      check("f_full_busy", 64'(busy), 64'd1);
      if (c == 4) full_ctl = 1'b0;
    end
    wait_drain("f", 80);
    check_grants("f");

    // One-cycle reset on beat 3 of requester 2: burst abandoned, requester 0 wins next.
    do_reset();
    push_pkt(2, 0, 6, 1'b1);
    expect_beats(2, 0, 0, 2);
    expect_beats(0, 0, 0, 2);
    expect_beats(2, 0, 2, 4);
    expect_grant(2, 2);
    expect_grant(0, 2);
    expect_grant(2, 4);
    wait_beat(beat_data(2, 0, 1), "g");
    push_pkt(0, 0, 2, 1'b1);
    rst_ctl = 1'b1;
    sample();
    check("g_rst_w_en", 64'(w_en), 64'd0);
    check("g_rst_req_ready", 64'(req_ready), 64'd0);
    check("g_rst_busy", 64'(busy), 64'd0);
    rst_ctl = 1'b0;
    sample();
    check("g_post_rst_idle", 64'(busy), 64'd0);
    check("g_post_rst_grant_id", 64'(grant_id), 64'd0);
    sample();
    check("g_regrant_busy", 64'(busy), 64'd1);
    check("g_regrant_owner", 64'(grant_id), 64'd0);
    wait_drain("g", 60);
    check_grants("g");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
